// File: rtl/seq_detect_param.sv
// Serial pattern detector: WIDTH-bit loadable pattern, overlap/non-overlap, Mealy/Moore det, saturating match count.
// Latency: Mealy det is combinational with the matching bit; Moore det follows one cycle after it.
// Backpressure: none; the block is always ready and in_vld qualifies each input bit.
module seq_detect_param #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] PAT_INIT = 3'b101,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] pat,
    input  logic             load,
    input  logic             overlap,
    input  logic             moore,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    // fill only ever needs to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    localparam int               FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WIDTH-1:0]  pat_q;
    logic [WIDTH-1:0]  pat_nxt;
    logic [WIDTH-2:0]  hist;
    logic [WIDTH-2:0]  hist_nxt;
    logic [WIDTH-2:0]  hist_shift;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              det_q;
    logic              hit;
    logic [CNT_W-1:0]  count_nxt;
    logic              ovf_nxt;

    // A match needs a full history window; load cycles never match because
    // the incoming bit is discarded and the pattern is being replaced.
    assign hit = in_vld & ~load & (fill == FILL_MAX) & ({hist, inp} == pat_q);

    // Both det paths are always live; moore only picks which one is visible.
    assign det = moore ? det_q : hit;

    // History shift: the oldest bit drops off the top, the new bit enters at the bottom.
    generate
        if (WIDTH == 2) begin : g_shift_w2
            assign hist_shift = inp;
        end else begin : g_shift_wn
            assign hist_shift = {hist[WIDTH-3:0], inp};
        end
    endgenerate

    // Saturating increment of the valid-bit count.
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);

    // Pattern and history next state: load wins, then a non-overlapping hit
    // discards the matched bits, otherwise a valid bit shifts in.
    always_comb begin
        pat_nxt  = pat_q;
        hist_nxt = hist;
        fill_nxt = fill;
        if (load) begin
            pat_nxt  = pat;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (in_vld) begin
            if (hit && !overlap) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = hist_shift;
                fill_nxt = fill_inc;
            end
        end
    end

    // Match counter next state: clear beats a coincident hit; a hit at
    // saturation leaves count alone and raises the sticky overflow flag.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = ovf;
        if (cnt_clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (hit) begin
            if (count != CNT_MAX) begin
                count_nxt = count + CNT_W'(1);
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // Detector state registers; reset restores the power-on pattern and empty history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PAT_INIT;
            hist  <= '0;
            fill  <= '0;
            det_q <= 1'b0;
        end else begin
            pat_q <= pat_nxt;
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            det_q <= hit;
        end
    end

    // Counter registers; load has no effect on these.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inp = 1'b0;
    logic         in_vld = 1'b0;
    logic [W-1:0] pat = '0;
    logic         load = 1'b0;
    logic         overlap = 1'b1;
    logic         moore = 1'b0;
    logic         cnt_clr = 1'b0;
    logic         det8, ovf8, det2, ovf2;
    logic [7:0]   count8;
    logic [1:0]   count2;

    int nvec = 0;
    int nmis = 0;

    seq_detect_param #(.WIDTH(W), .PAT_INIT(3'b101), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .inp(inp), .in_vld(in_vld), .pat(pat), .load(load),
        .overlap(overlap), .moore(moore), .cnt_clr(cnt_clr),
        .det(det8), .count(count8), .ovf(ovf8)
    );

    seq_detect_param #(.WIDTH(W), .PAT_INIT(3'b101), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .inp(inp), .in_vld(in_vld), .pat(pat), .load(load),
        .overlap(overlap), .moore(moore), .cnt_clr(cnt_clr),
        .det(det2), .count(count2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       inp;
        bit       vld;
        bit       load;
        bit [2:0] pat;
        bit       ovl;
        bit       moore;
        bit       clr;
        bit       edet;
        int       ecnt;
    } row_t;

    row_t rows[$];

    // Reference model: the valid bits seen since the last clear, newest last.
    bit       mq[$];
    bit [2:0] m_pat;
    bit       m_detq;
    int       m_cnt8, m_cnt2;
    bit       m_ovf8, m_ovf2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit i_inp, input bit i_vld, input bit i_load, input bit [2:0] i_pat,
                         input bit i_ovl, input bit i_moore, input bit i_clr);
        inp     = i_inp;
        in_vld  = i_vld;
        load    = i_load;
        pat     = i_pat;
        overlap = i_ovl;
        moore   = i_moore;
        cnt_clr = i_clr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void add(bit i, bit v, bit l, bit [2:0] p, bit o, bit m, bit c, bit d, int n);
        row_t r;
        r.inp = i; r.vld = v; r.load = l; r.pat = p; r.ovl = o;
        r.moore = m; r.clr = c; r.edet = d; r.ecnt = n;
        rows.push_back(r);
    endfunction

    function automatic void fill_table();
        bit s1[7] = '{0, 1, 0, 1, 1, 0, 1};
        bit s2[5] = '{1, 0, 1, 0, 1};
        int m;
        // Mealy, overlapping: hits on bits 4 and 7
        add(0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(s1[i], 1, 0, 3'b000, 1, 0, 0, (i == 3 || i == 6), (i >= 4) ? 1 : 0);
        add(1, 0, 0, 3'b000, 1, 0, 0, 0, 2);
        add(0, 0, 0, 3'b000, 1, 0, 1, 0, 2);
        // Moore: pulses one cycle after bits 4 and 7
        add(0, 0, 1, 3'b101, 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(s1[i], 1, 0, 3'b000, 1, 1, 0, (i == 4), (i >= 4) ? 1 : 0);
        add(0, 0, 0, 3'b000, 1, 1, 0, 1, 2);
        add(0, 0, 0, 3'b000, 1, 1, 0, 0, 2);
        add(0, 0, 0, 3'b000, 1, 1, 1, 0, 2);
        // 1,0,1,0,1 overlapping: hits on bits 3 and 5
        add(0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(s2[i], 1, 0, 3'b000, 1, 0, 0, (i == 2 || i == 4), (i >= 3) ? 1 : 0);
        add(0, 0, 0, 3'b000, 1, 0, 0, 0, 2);
        add(0, 0, 0, 3'b000, 1, 0, 1, 0, 2);
        // 1,0,1,0,1 non-overlapping: hit on bit 3 only
        add(0, 0, 1, 3'b101, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(s2[i], 1, 0, 3'b000, 0, 0, 0, (i == 2), (i >= 3) ? 1 : 0);
        add(0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
        add(0, 0, 0, 3'b000, 0, 0, 1, 0, 1);
        // Two invalid cycles between every bit, inp toggling in the gaps
        add(0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
        m = 0;
        for (int i = 0; i < 7; i++) begin
            bit h;
            h = (i == 3 || i == 6);
            add(s1[i], 1, 0, 3'b000, 1, 0, 0, h, m);
            m += int'(h);
            add(!s1[i], 0, 0, 3'b000, 1, 0, 0, 0, m);
            add(s1[i], 0, 0, 3'b000, 1, 0, 0, 0, m);
        end
        add(0, 0, 0, 3'b000, 1, 0, 1, 0, 2);
        // Load 110 mid-stream after 1,1 (the load-cycle bit is ignored), then 1,1,0
        add(0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 1, 1, 3'b110, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3'b000, 1, 0, 0, 0, 0);
        add(0, 1, 0, 3'b000, 1, 0, 0, 1, 0);
        add(0, 0, 0, 3'b000, 1, 0, 0, 0, 1);
        add(0, 0, 0, 3'b000, 1, 0, 1, 0, 1);
    endfunction

    function automatic bit m_hit(bit i, bit v, bit l);
        int val;
        if (!v || l) return 1'b0;
        if (mq.size() < W - 1) return 1'b0;
        val = 0;
        foreach (mq[k]) val = val * 2 + int'(mq[k]);
        val = val * 2 + int'(i);
        return val == int'(m_pat);
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_pat  = 3'b101;
        m_detq = 1'b0;
        m_cnt8 = 0; m_cnt2 = 0;
        m_ovf8 = 1'b0; m_ovf2 = 1'b0;
    endfunction

    function automatic void m_step(bit i, bit v, bit l, bit [2:0] p, bit o, bit c, bit h);
        m_detq = h;
        if (l) begin
            mq.delete();
            m_pat = p;
        end else if (v) begin
            if (h && !o) mq.delete();
            else begin
                mq.push_back(i);
                if (mq.size() > W - 1) void'(mq.pop_front());
            end
        end
        if (c) begin
            m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 1'b0; m_ovf2 = 1'b0;
        end else if (h) begin
            if (m_cnt8 < 255) m_cnt8++; else m_ovf8 = 1'b1;
            if (m_cnt2 < 3) m_cnt2++; else m_ovf2 = 1'b1;
        end
    endfunction

    initial begin
        fill_table();

        // Reset state, with inputs wiggling across an edge while held in reset
        #2;
        chk("reset det", det8, 0);
        chk("reset count", count8, 0);
        chk("reset ovf", ovf8, 0);
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 1, 0, 1);
        tick();
        chk("reset hold count2", count2, 0);
        chk("reset hold det", det8, 0);
        drive(0, 0, 0, 3'b000, 1, 0, 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors
        for (int r = 0; r < rows.size(); r++) begin
            drive(rows[r].inp, rows[r].vld, rows[r].load, rows[r].pat, rows[r].ovl, rows[r].moore, rows[r].clr);
            #2;
            chk($sformatf("row%0d det", r), det8, rows[r].edet);
            chk($sformatf("row%0d count", r), count8, rows[r].ecnt);
            tick();
        end

        // Saturation with a 2-bit counter: five matches of 1,0,1,0,...
        chk("sat pre count2", count2, 0);
        chk("sat pre ovf2", ovf2, 0);
        drive(0, 0, 1, 3'b101, 1, 0, 0);
        tick();
        for (int i = 0; i < 11; i++) begin
            drive((i % 2) == 0, 1, 0, 3'b000, 1, 0, 0);
            tick();
            if (i == 6) begin
                chk("sat three count2", count2, 3);
                chk("sat three ovf2", ovf2, 0);
            end
        end
        chk("sat count2", count2, 3);
        chk("sat ovf2", ovf2, 1);
        chk("sat count8", count8, 5);
        chk("sat ovf8", ovf8, 0);
        drive(0, 0, 1, 3'b101, 1, 0, 0);
        tick();
        chk("load keeps count2", count2, 3);
        chk("load keeps ovf2", ovf2, 1);
        drive(1, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(0, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(1, 1, 0, 3'b000, 1, 0, 1);
        #2 chk("clr+hit det", det8, 1);
        tick();
        drive(0, 0, 0, 3'b000, 1, 0, 0);
        chk("clr+hit count2", count2, 0);
        chk("clr+hit ovf2", ovf2, 0);
        chk("clr+hit count8", count8, 0);

        // Reset mid-stream, then history must be empty and pattern back to 101
        drive(0, 0, 1, 3'b101, 1, 0, 0); tick();
        drive(1, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(0, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(1, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(0, 1, 0, 3'b000, 1, 0, 0); tick();
        chk("pre-rst count8", count8, 1);
        #1 rst = 1'b0;
        #1;
        chk("async rst count8", count8, 0);
        chk("async rst count2", count2, 0);
        chk("async rst det", det8, 0);
        chk("async rst ovf", ovf8, 0);
        drive(1, 1, 1, 3'b000, 1, 0, 0);
        tick();
        chk("rst ignores inputs count8", count8, 0);
        drive(0, 0, 0, 3'b000, 1, 0, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 1, 0, 0);
        #2 chk("post-rst lone bit det", det8, 0);
        tick();
        drive(0, 1, 0, 3'b000, 1, 0, 0); tick();
        drive(1, 1, 0, 3'b000, 1, 0, 0);
        #2 chk("post-rst PAT_INIT det", det8, 1);
        tick();
        chk("post-rst count8", count8, 1);

        // Randomized run against the reference model
        #1 rst = 1'b0;
        m_reset();
        drive(0, 0, 0, 3'b000, 1, 0, 0);
        tick();
        #2 rst = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            bit ri, rv, rl, ro, rm, rc, h, ed;
            bit [2:0] rp;
            ri = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 39) == 0);
            rp = 3'($urandom_range(0, 7));
            ro = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 99) == 0);
            drive(ri, rv, rl, rp, ro, rm, rc);
            #2;
            h  = m_hit(ri, rv, rl);
            ed = rm ? m_detq : h;
            chk($sformatf("rand%0d det8", c), det8, ed);
            chk($sformatf("rand%0d det2", c), det2, ed);
            chk($sformatf("rand%0d count8", c), count8, m_cnt8);
            chk($sformatf("rand%0d ovf8", c), ovf8, m_ovf8);
            chk($sformatf("rand%0d count2", c), count2, m_cnt2);
            chk($sformatf("rand%0d ovf2", c), ovf2, m_ovf2);
            m_step(ri, rv, rl, rp, ro, rc, h);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH     3       pattern length in bits, legal range 2..16
  PAT_INIT  3'b101  pattern value loaded at reset, WIDTH bits
  CNT_W     8       match-counter width, legal range 1..32
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk      in   1      single clock, rising edge
  rst      in   1      asynchronous, active-low reset
  inp      in   1      serial data bit
  in_vld   in   1      inp is valid this cycle
  pat      in   WIDTH  pattern to load; MSB is the oldest bit
  load     in   1      latch pat and clear history
  overlap  in   1      1 = overlapping detection, 0 = non-overlapping
  moore    in   1      1 = registered (Moore) det, 0 = combinational (Mealy) det
  cnt_clr  in   1      synchronous clear of count and ovf
  det      out  1      match indication
  count    out  CNT_W  number of matches, saturating
  ovf      out  1      sticky: a match occurred while count was saturated
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low, on port rst.

Function
REQ-004 Internal state SHALL be:
  - pat_q (WIDTH bits)
  - hist (WIDTH-1 bits, shift register of past valid bits)
  - fill (count of valid history bits, saturating at WIDTH-1)
  - det_q (1 bit)
REQ-005 hit SHALL be combinational: in_vld & ~load & (fill == WIDTH-1) & ({hist, inp} == pat_q).
REQ-006 det SHALL equal hit when moore=0, and SHALL equal det_q when moore=1.
REQ-007 The moore input SHALL only select the det output; both det paths SHALL update every cycle regardless of mode.
REQ-008 On each rising edge, det_q <= hit; the Moore latency SHALL be exactly one cycle after the matching bit.
REQ-009 On a rising edge with load=1, the block SHALL:
  - set pat_q <= pat,
  - clear hist and fill,
  - force det_q <= 0,
  - ignore inp and in_vld that cycle.
REQ-010 On a rising edge with load=0 and in_vld=0, hist and fill SHALL hold.
REQ-011 On a rising edge with load=0 and in_vld=1 and (hit=0 or overlap=1), the block SHALL shift: hist <= {hist[WIDTH-3:0], inp}, and fill <= min(fill+1, WIDTH-1).
REQ-012 For WIDTH=2, the shift in REQ-011 SHALL reduce to hist <= inp.
REQ-013 On a rising edge with hit=1 and overlap=0, hist and fill SHALL clear to 0, so no matched bit is reused.
REQ-014 Counter behaviour, priority highest first:
  - cnt_clr=1 -> count <= 0 and ovf <= 0, even if hit=1 that cycle;
  - hit=1 and count < all-ones -> count <= count+1;
  - hit=1 and count == all-ones -> count holds and ovf <= 1.
REQ-015 ovf SHALL stay set until cnt_clr or reset.
REQ-016 load SHALL NOT alter count or ovf.
REQ-017 overlap and moore SHALL be sampled live each cycle; changing them mid-stream SHALL NOT clear history.

Reset
REQ-018 While rst=0, outputs SHALL be asynchronously forced to det=0, count=0, ovf=0.
REQ-019 While rst=0, internal state SHALL be asynchronously forced to pat_q=PAT_INIT, hist=0, fill=0, det_q=0.
REQ-020 While rst=0, inputs SHALL be ignored.
REQ-021 The first edge after rst rises SHALL operate normally; the bench SHALL release rst away from the clk edge.

Verification
REQ-022 Bench parameters: WIDTH=3, PAT_INIT=3'b101.
REQ-023 The bench SHALL cover these directed scenarios:
  - Mealy, overlap=1, in_vld=1, bits 0,1,0,1,1,0,1 -> det high during bits 4 and 7 only; count=2.
  - Overlap check, bits 1,0,1,0,1: overlap=1 -> det on bits 3 and 5, count=2; overlap=0 -> det on bit 3 only, count=1.
  - Moore mode with the first stream above -> det high one cycle after bits 4 and 7, each pulse one cycle wide.
  - Gaps: repeat the first stream with in_vld=0 for two cycles between every bit (inp toggling freely during gaps) -> same two detections, count=2.
  - Load: load pat=3'b110 mid-stream after bits 1,1 -> no det from pre-load bits; then bits 1,1,0 -> one det, count incremented by 1.
  - Saturation: CNT_W=2, five matches -> count=3 and ovf=1; then cnt_clr asserted on the same cycle as a hit -> count=0, ovf=0.
  - Reset mid-stream: assert rst after bits 1,0 -> outputs zero immediately; after release, bit 1 alone -> no det.
